prescaler_tick_gen: RTL and testbench
=====================================

// Module: prescaler_tick_gen
// PURPOSE
// Parametrised multi-channel prescaler. Derives N_CH independent tick and square outputs from clk_in.
// These outputs drive slow FSM stepping and LED/display pacing on the Basys 3.
// Each channel has a runtime-programmable divisor (period D cycles, D>=2) and a periodic/one-shot mode.
// Divisor changes go through a valid/ready config port and apply glitch-free at the channel's period boundary.
// All logic runs in the clk_in domain. Outputs are clock enables and levels, never used as clocks.
// PARAMETERS
// N_CH     4            number of channels (1..16)
// CNT_W    27           counter/divisor width in bits
// DEF_DIV  100_000_000  reset divisor, all channels (1 Hz tick at 100 MHz); must be >=2 and < 2**CNT_W
// CH_W     $clog2(N_CH) (min 1) channel-select width, derived
// PORTS
// clk_in     in   1         system clock, 100 MHz
// reset      in   1         synchronous, active-high reset
// run        in   N_CH      per-channel count enable
// sync_clr   in   1         restart all channel counters together (phase alignment)
// cfg_valid  in   1         config request
// cfg_ready  out  1         config can be accepted
// cfg_ch     in   CH_W      target channel
// cfg_div    in   CNT_W     new divisor D
// cfg_mode   in   1         0 = periodic, 1 = one-shot
// cfg_err    out  1         1-cycle pulse: rejected config
// tick_o     out  N_CH      1-cycle pulse per period
// sq_o       out  N_CH      square wave with period D
// BEHAVIOUR
// Clock and reset: one clock, clk_in. Reset is synchronous and active-high.
// Reset values: cnt=0, div=DEF_DIV, mode=periodic, done=0, no pending config.
// Reset outputs: tick_o=0, sq_o=0, cfg_err=0, cfg_ready=1. Reset has priority over everything.
// Per-channel counter: on each edge with run[i]=1 and done[i]=0, cnt counts 0..D-1 and then wraps to 0.
// Wrap edge: tick_o[i] is registered 1 for the single cycle following the wrap edge, otherwise 0.
// No tick is issued at reset, at run start, or on sync_clr.
// sq_o[i]: registered, equals (cnt >= D-(D>>1)). Low for ceil(D/2) cycles, high for floor(D/2) cycles.
//   Example: D=4 gives cnt 0,1,2,3,0 and sq_o 0,0,1,1,0.
// run[i]=0: cnt and sq_o[i] hold, tick_o[i]=0.
// Periodic mode: counts continuously.
// One-shot mode: on the first wrap, tick_o pulses once and done[i] is set. cnt then stays 0, sq_o=0.
//   done[i] clears on a run[i] 1->0 transition, on sync_clr, or on a config applied to that channel.
// sync_clr: all cnt=0, sq_o=0, tick_o=0, done=0 on that edge. Priority: sync_clr over run.
// Config handshake: accept = cfg_valid & cfg_ready.
//   Rejected if cfg_div<2 or cfg_ch>=N_CH: cfg_err=1 next cycle, nothing staged, cfg_ready stays 1.
//   Otherwise {ch,div,mode} is staged in one pending register and cfg_ready=0 from the next cycle.
// Pending config is applied on the first of these edges:
//   (a) the target channel's wrap edge (its tick still fires for the old period);
//   (b) the next edge, if the target has run=0 or done=1;
//   (c) a sync_clr edge.
// On apply: div/mode are loaded, cnt=0, done=0, sq_o=0. cfg_ready=1 from the following cycle.
// Only one pending config at a time. cfg_valid while cfg_ready=0 is ignored (requester must hold).
// Reset while pending: the pending config is discarded and the DEF_DIV settings are restored.
// Width rules: compare and increment are unsigned CNT_W-bit. cnt never exceeds D-1, so there is no overflow.
// TESTING (N_CH=2, DEF_DIV=4)
// Reset then run=2'b11 -> tick_o[0] pulses every 4 cycles, first pulse 4 cycles after run; sq_o[0] pattern 0,0,1,1 repeats.
// Config ch1 div=5 mode=0 mid-period -> cfg_ready drops; ch1 completes its current 4-cycle period with a tick; then period 5, sq_o 0,0,0,1,1.
// Config div=1 or ch=3 (N_CH=2) -> cfg_err 1-cycle pulse; no setting changes; cfg_ready stays 1.
// ch0 one-shot div=3, run held -> exactly one tick 3 cycles after apply, then silence; run 1->0->1 -> exactly one more tick.
// Channels with different phases, assert sync_clr -> both cnt=0; with equal D, subsequent ticks coincide; sync_clr with run=0 still clears.
// Reset asserted during a pending config -> cfg_ready=1, div=4 for all channels, no ticks during reset.

Source files
------------

// File: rtl/prescaler_tick_gen.sv
// Multi-channel prescaler. Each channel divides clk_in by a runtime-programmable
// divisor and produces a one-cycle tick (clock enable) plus a square-wave level.
// New divisors arrive through a single-entry valid/ready config port and take
// effect at the target channel's period boundary so no period is ever truncated.
module prescaler_tick_gen #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 27,
    parameter int DEF_DIV = 100_000_000,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [N_CH-1:0]   run,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic [N_CH-1:0]   tick_o,
    output logic [N_CH-1:0]   sq_o
);

    // Square level for a given count: low for ceil(D/2) counts, high for floor(D/2).
    function automatic logic sq_level(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] div);
        return cnt >= (div - (div >> 1));
    endfunction

    // Pending config slot (control flag plus captured payload).
    logic              r_pend;
    logic [CH_W-1:0]   r_pch;
    logic [CNT_W-1:0]  r_pdiv;
    logic              r_pmode;
    logic              r_err;

    logic              w_cfg_bad;
    logic              w_try;
    logic              w_accept;
    logic [N_CH-1:0]   w_apply;

    assign w_cfg_bad = (cfg_div < CNT_W'(2)) || (int'(cfg_ch) >= N_CH);
    assign w_try     = cfg_valid && !r_pend;
    assign w_accept  = w_try && !w_cfg_bad;

    assign cfg_ready = !r_pend;
    assign cfg_err   = r_err;

    // Config control: accept/reject requests, release the slot once applied.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_try && w_cfg_bad;
            if (r_pend && (sync_clr || (|w_apply))) begin
                r_pend <= 1'b0;
            end else if (w_accept) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Capture the payload of an accepted request; only meaningful while r_pend=1.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_pch   <= cfg_ch;
            r_pdiv  <= cfg_div;
            r_pmode <= cfg_mode;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic             r_mode;
        logic             r_done;
        logic             r_tick;
        logic             r_sq;
        logic             r_run_d;

        logic             w_sel;
        logic             w_active;
        logic             w_wrap;
        logic             w_apply_ch;
        logic [CNT_W-1:0] w_cnt_inc;

        assign w_sel      = r_pend && (int'(r_pch) == gi);
        assign w_active   = run[gi] && !r_done;
        assign w_wrap     = w_active && (r_cnt == (r_div - CNT_W'(1)));
        // Apply at the wrap edge, or immediately when the channel is idle/finished.
        assign w_apply_ch = w_sel && (w_wrap || !run[gi] || r_done);
        assign w_cnt_inc  = r_cnt + CNT_W'(1);

        assign w_apply[gi] = w_apply_ch;
        assign tick_o[gi]  = r_tick;
        assign sq_o[gi]    = r_sq;

        // Channel counter, tick/square generation, one-shot latch and config load.
        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_cnt   <= '0;
                r_div   <= CNT_W'(DEF_DIV);
                r_mode  <= 1'b0;
                r_done  <= 1'b0;
                r_tick  <= 1'b0;
                r_sq    <= 1'b0;
                r_run_d <= 1'b0;
            end else begin
                r_run_d <= run[gi];
                if (sync_clr) begin
                    r_cnt  <= '0;
                    r_sq   <= 1'b0;
                    r_tick <= 1'b0;
                    r_done <= 1'b0;
                    if (w_sel) begin
                        r_div  <= r_pdiv;
                        r_mode <= r_pmode;
                    end
                end else begin
                    // The tick for the closing period still fires on an apply edge.
                    r_tick <= w_wrap;
                    if (w_apply_ch) begin
                        r_div  <= r_pdiv;
                        r_mode <= r_pmode;
                        r_cnt  <= '0;
                        r_done <= 1'b0;
                        r_sq   <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt <= '0;
                        r_sq  <= 1'b0;
                        if (r_mode) begin
                            r_done <= 1'b1;
                        end
                    end else if (w_active) begin
                        r_cnt <= w_cnt_inc;
                        r_sq  <= sq_level(w_cnt_inc, r_div);
                    end else if (r_run_d && !run[gi]) begin
                        // Dropping run re-arms a finished one-shot channel.
                        r_done <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prescaler_tick_gen.sv
// Bench for prescaler_tick_gen with N_CH=2, DEF_DIV=4. Stimulus schedules
// hand-computed per-cycle expectations into a queue; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_prescaler_tick_gen;

    localparam int N_CH  = 2;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic              clk_in;
    logic              reset;
    logic [N_CH-1:0]   run;
    logic              sync_clr;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic              cfg_err;
    logic [N_CH-1:0]   tick_o;
    logic [N_CH-1:0]   sq_o;

    prescaler_tick_gen #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (4),
        .CH_W    (CH_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run       (run),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .tick_o    (tick_o),
        .sq_o      (sq_o)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] tick;
        logic [1:0] sq;
        logic [1:0] m;
        logic       err;
        logic       rdy;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    // Expected-value tables, one entry per cycle: {tick[1:0], sq[1:0], cfg_err, cfg_ready}.
    localparam logic [5:0] S1 [8] = '{
        6'b000001, 6'b001101, 6'b001101, 6'b110001,
        6'b000001, 6'b001101, 6'b001101, 6'b110001};
    localparam logic [5:0] S2 [13] = '{
        6'b001100, 6'b001100, 6'b110001, 6'b000001, 6'b000101,
        6'b001101, 6'b011001, 6'b100001, 6'b000101, 6'b000101,
        6'b011001, 6'b001001, 6'b100101};
    localparam logic [5:0] S3 [6] = '{
        6'b000111, 6'b010011, 6'b001001, 6'b001101, 6'b100101, 6'b010001};
    localparam logic [5:0] S4 [20] = '{
        6'b000000, 6'b000100, 6'b000100, 6'b010001, 6'b000001,
        6'b000101, 6'b010001, 6'b000001, 6'b000001, 6'b000001,
        6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000101,
        6'b010001, 6'b000001, 6'b000001, 6'b000001, 6'b000001};
    localparam logic [5:0] S5 [20] = '{
        6'b000000, 6'b001001, 6'b001001, 6'b100001, 6'b000001,
        6'b000001, 6'b000001, 6'b001101, 6'b001101, 6'b110001,
        6'b000001, 6'b000001, 6'b001101, 6'b001101, 6'b000001,
        6'b000001, 6'b000001, 6'b001101, 6'b001101, 6'b110001};
    localparam logic [5:0] S6 [11] = '{
        6'b000000, 6'b000001, 6'b000001, 6'b000001, 6'b001101,
        6'b001101, 6'b110001, 6'b000001, 6'b001101, 6'b001101,
        6'b110001};

    task automatic push(input int dc, input logic [5:0] v, input logic [1:0] m,
                        input string nm);
        exp_t x;
        x.cyc  = cyc + dc;
        x.tick = v[5:4];
        x.sq   = v[3:2];
        x.err  = v[1];
        x.rdy  = v[0];
        x.m    = m;
        x.nm   = nm;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic cmp(input string nm, input string fld, input int c,
                       input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s cyc=%0d: got %b, expected %b", nm, fld, c, act, exp);
        end
    endtask

    // Monitor: compare every scheduled expectation at the cycle it refers to.
    always @(negedge clk_in) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale entry for cyc=%0d at cyc=%0d", e.nm, e.cyc, cyc);
            end else begin
                cmp(e.nm, "tick", cyc, tick_o & e.m, e.tick & e.m);
                cmp(e.nm, "sq",   cyc, sq_o & e.m,   e.sq & e.m);
                cmp(e.nm, "err",  cyc, {1'b0, cfg_err},   {1'b0, e.err});
                cmp(e.nm, "rdy",  cyc, {1'b0, cfg_ready}, {1'b0, e.rdy});
            end
        end
    end

    task automatic cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv,
                       input logic md);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_mode  = md;
    endtask

    initial begin
        reset     = 1'b1;
        run       = '0;
        sync_clr  = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_mode  = 1'b0;
        step(2);

        // Reset held with run asserted: no ticks, ready high.
        run = 2'b11;
        push(1, 6'b000001, 2'b11, "reset");
        push(2, 6'b000001, 2'b11, "reset");
        step(2);

        // Release: both channels divide by 4.
        reset = 1'b0;
        for (int j = 0; j < 8; j++) push(j + 1, S1[j], 2'b11, "div4");
        step(8);

        // Mid-period reconfigure ch1 to D=5 periodic.
        step(1);
        for (int j = 0; j < 13; j++) push(j + 1, S2[j], 2'b11, "cfg_ch1");
        cfg(2'd1, 8'd5, 1'b0);
        step(1);
        cfg_valid = 1'b0;
        step(12);

        // Rejected configs: divisor too small, channel out of range.
        for (int j = 0; j < 6; j++) push(j + 1, S3[j], 2'b11, "cfg_err");
        cfg(2'd1, 8'd1, 1'b0);
        step(1);
        cfg(2'd3, 8'd5, 1'b0);
        step(1);
        cfg_valid = 1'b0;
        step(4);

        // ch0 one-shot D=3, then re-arm by toggling run.
        for (int j = 0; j < 20; j++) push(j + 1, S4[j], 2'b01, "oneshot");
        cfg(2'd0, 8'd3, 1'b1);
        step(1);
        cfg_valid = 1'b0;
        step(11);
        run = 2'b10;
        step(1);
        run = 2'b11;
        step(7);

        // ch0 back to periodic D=5 (applies at once since done), then sync_clr.
        for (int j = 0; j < 20; j++) push(j + 1, S5[j], 2'b11, "sync_clr");
        cfg(2'd0, 8'd5, 1'b0);
        step(1);
        cfg_valid = 1'b0;
        step(3);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        step(8);
        run = 2'b00;
        step(1);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        run = 2'b11;
        step(5);

        // Reset while a config is pending: discarded, defaults restored.
        for (int j = 0; j < 11; j++) push(j + 1, S6[j], 2'b11, "reset_pend");
        cfg(2'd1, 8'd7, 1'b0);
        step(1);
        cfg_valid = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(8);

        step(2);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
